// File: rtl/seg7_pkg.sv
// Shared types and constants for the 4-digit 7-segment scan driver.
package seg7_pkg;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_BLANK = 2'd1,
        S_SCAN  = 2'd2
    } seg7_state_t;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned DIGIT_W    = $clog2(NUM_DIGITS);

    localparam logic [6:0] SEG_OFF   = 7'h7F;
    localparam logic [3:0] ANODE_OFF = 4'hF;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
    localparam logic [6:0] HEX_SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment decoder.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg_c
);

    // Table lookup of the segment pattern
    assign o_seg_c = HEX_SEG[i_nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-segment driver with per-frame shadow capture
// and dead-time blanking between digits.
// Optional build macro SEG7_BLANK_LEADING_ZERO_EN blanks leading zero digits.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned BLANK_CYCLES = 2
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [15:0] value,
    input  logic        disp,
    input  logic        freeze,
    output logic [3:0]  anode,
    output logic [6:0]  seg,
    output logic        frame_done
);

    localparam int unsigned TMAX       = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int unsigned TW         = $clog2(TMAX + 1);
    localparam int unsigned SCAN_LAST  = SCAN_DIV - 1;
    localparam int unsigned BLANK_LAST = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
    localparam bit          HAS_BLANK  = (BLANK_CYCLES > 0);

    seg7_state_t          r_state;
    logic [DIGIT_W-1:0]   r_digit;
    logic [TW-1:0]        r_timer;
    logic [15:0]          r_shadow;

    seg7_state_t          w_state_nx;
    logic [DIGIT_W-1:0]   w_digit_nx;
    logic [TW-1:0]        w_timer_nx;
    logic [15:0]          w_shadow_nx;
    logic [3:0]           w_nibble;
    logic [6:0]           w_dec;
    logic                 w_lead_blank;
    logic                 w_lit;
    logic [3:0]           w_anode_nx;
    logic [6:0]           w_seg_nx;
    logic                 w_frame_done_nx;

    // Next-state, next-digit, timer and shadow reload
    always_comb begin
        w_state_nx  = r_state;
        w_digit_nx  = r_digit;
        w_timer_nx  = r_timer + TW'(1);
        w_shadow_nx = r_shadow;
        case (r_state)
            S_LOAD: begin
                if (!freeze) begin
                    w_shadow_nx = value;
                end
                w_digit_nx = '0;
                w_timer_nx = '0;
                w_state_nx = HAS_BLANK ? S_BLANK : S_SCAN;
            end
            S_BLANK: begin
                if (r_timer == TW'(BLANK_LAST)) begin
                    w_timer_nx = '0;
                    w_state_nx = S_SCAN;
                end
            end
            S_SCAN: begin
                if (r_timer == TW'(SCAN_LAST)) begin
                    w_timer_nx = '0;
                    if (r_digit == DIGIT_W'(NUM_DIGITS - 1)) begin
                        w_state_nx = S_LOAD;
                    end else begin
                        w_digit_nx = r_digit + DIGIT_W'(1);
                        w_state_nx = HAS_BLANK ? S_BLANK : S_SCAN;
                    end
                end
            end
            default: begin
                w_state_nx = S_LOAD;
                w_digit_nx = '0;
                w_timer_nx = '0;
            end
        endcase
    end

    // Nibble of the next shadow selected by the next digit
    always_comb begin
        w_nibble = w_shadow_nx[3:0];
        case (w_digit_nx)
            2'd0:    w_nibble = w_shadow_nx[3:0];
            2'd1:    w_nibble = w_shadow_nx[7:4];
            2'd2:    w_nibble = w_shadow_nx[11:8];
            default: w_nibble = w_shadow_nx[15:12];
        endcase
    end

    hex_to_seg7 u_dec (
        .i_nibble (w_nibble),
        .o_seg_c  (w_dec)
    );

`ifdef SEG7_BLANK_LEADING_ZERO_EN
    // Digit is blank when it and every higher nibble are zero; digit 0 always shows
    always_comb begin
        w_lead_blank = 1'b0;
        case (w_digit_nx)
            2'd0:    w_lead_blank = 1'b0;
            2'd1:    w_lead_blank = (w_shadow_nx[15:4] == 12'h000);
            2'd2:    w_lead_blank = (w_shadow_nx[15:8] == 8'h00);
            default: w_lead_blank = (w_shadow_nx[15:12] == 4'h0);
        endcase
    end
`else
    assign w_lead_blank = 1'b0;
`endif

    // Pin values for the coming cycle; disp only gates the pins
    always_comb begin
        w_lit           = (w_state_nx == S_SCAN) && disp;
        w_anode_nx      = w_lit ? ~(4'b0001 << w_digit_nx) : ANODE_OFF;
        w_seg_nx        = (w_lit && !w_lead_blank) ? w_dec : SEG_OFF;
        w_frame_done_nx = (w_state_nx == S_SCAN)
                       && (w_digit_nx == DIGIT_W'(NUM_DIGITS - 1))
                       && (w_timer_nx == TW'(SCAN_LAST));
    end

    // State and registered outputs update on the same edge
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state    <= S_LOAD;
            r_digit    <= '0;
            r_timer    <= '0;
            r_shadow   <= 16'h0000;
            anode      <= ANODE_OFF;
            seg        <= SEG_OFF;
            frame_done <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_digit    <= w_digit_nx;
            r_timer    <= w_timer_nx;
            r_shadow   <= w_shadow_nx;
            anode      <= w_anode_nx;
            seg        <= w_seg_nx;
            frame_done <= w_frame_done_nx;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with SCAN_DIV=4, BLANK_CYCLES=1 (21-cycle frame).
module tb_seg7_scan_driver;

    logic        clock;
    logic        clear;
    logic [15:0] value;
    logic        disp;
    logic        freeze;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic        frame_done;

    int checks;
    int failures;
    int frame_no;

    logic [6:0] hex_tbl [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    seg7_scan_driver #(
        .SCAN_DIV     (4),
        .BLANK_CYCLES (1)
    ) dut (
        .clock      (clock),
        .clear      (clear),
        .value      (value),
        .disp       (disp),
        .freeze     (freeze),
        .anode      (anode),
        .seg        (seg),
        .frame_done (frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Checks one frame from its S_LOAD cycle; disp is dropped after position
    // clr_p and restored after set_p; value changes after chg_p.
    task automatic run_frame(input logic [15:0] val, input int clr_p, input int set_p,
                             input int chg_p, input logic [15:0] chg_val);
        logic [3:0]  ea;
        logic [6:0]  es;
        logic [15:0] upper;
        logic        off;
        int          d;
        frame_no++;
        for (int p = 1; p <= 21; p++) begin
            ea  = 4'hF;
            es  = 7'h7F;
            off = (clr_p > 0) && (p > clr_p) && ((set_p == 0) || (p <= set_p));
            if (p != 1 && ((p - 2) % 5) != 0 && !off) begin
                d     = (p - 3) / 5;
                ea    = ~(4'(1) << d);
                upper = val >> (4 * d);
                es    = hex_tbl[upper[3:0]];
`ifdef SEG7_BLANK_LEADING_ZERO_EN
                if (d > 0 && upper == 16'h0000) es = 7'h7F;
`endif
            end
            chk($sformatf("f%0d_p%0d_anode", frame_no, p), 16'(anode), 16'(ea));
            chk($sformatf("f%0d_p%0d_seg", frame_no, p), 16'(seg), 16'(es));
            chk($sformatf("f%0d_p%0d_fdone", frame_no, p), 16'(frame_done), 16'(p == 21));
            if (p == clr_p) disp = 1'b0;
            if (p == set_p) disp = 1'b1;
            if (p == chg_p) value = chg_val;
            @(posedge clock);
            #1;
            if (p == 1) freeze = 1'b0;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        frame_no = 0;
        clear    = 1'b0;
        value    = 16'h1234;
        disp     = 1'b1;
        freeze   = 1'b0;

        // Reset values held while clear is low
        repeat (3) @(posedge clock);
        #1;
        chk("rst_anode", 16'(anode), 16'hF);
        chk("rst_seg", 16'(seg), 16'h7F);
        chk("rst_fdone", 16'(frame_done), 16'h0);

        @(negedge clock);
        clear = 1'b1;

        // 1234, value changes mid-frame to ABCD
        run_frame(16'h1234, 0, 0, 10, 16'hABCD);
        // ABCD shown next frame; value returns to 1234
        run_frame(16'hABCD, 0, 0, 5, 16'h1234);
        // 1234, then FFFF presented with freeze on the load cycle
        run_frame(16'h1234, 0, 0, 21, 16'hFFFF);
        freeze = 1'b1;
        run_frame(16'h1234, 0, 0, 0, 16'h0000);
        run_frame(16'hFFFF, 0, 0, 0, 16'h0000);
        // Display disabled across the whole frame
        run_frame(16'hFFFF, 1, 21, 0, 16'h0000);
        // Display re-enabled mid-digit 0
        run_frame(16'hFFFF, 1, 4, 21, 16'h0050);
        run_frame(16'h0050, 0, 0, 21, 16'h0000);
        run_frame(16'h0000, 0, 0, 21, 16'h1234);

        // Asynchronous reset while digit 2 is lit
        repeat (13) @(posedge clock);
        #1;
        chk("pre_rst_anode", 16'(anode), 16'b1011);
        chk("pre_rst_seg", 16'(seg), 16'(hex_tbl[2]));
        clear = 1'b0;
        #2;
        chk("async_rst_anode", 16'(anode), 16'hF);
        chk("async_rst_seg", 16'(seg), 16'h7F);
        chk("async_rst_fdone", 16'(frame_done), 16'h0);
        value = 16'h5678;
        #2;
        clear = 1'b1;
        run_frame(16'h5678, 0, 0, 0, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety bound on total run time
    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
